// File: rtl/radix4_otf_convert.sv
// radix4_otf_convert: on-the-fly conversion of a signed radix-4 digit stream into a
// two's-complement integer, keeping Q and QM=Q-1 so negative digits never need a carry.
module radix4_otf_convert #(
    parameter int no_of_digits = 4,
    parameter int radix_bits   = 3,
    parameter int radix        = 4,
    parameter int delta        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [radix_bits-1:0]     din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [2*no_of_digits:0]   dout,
    output logic                      dout_valid,
    output logic                      digit_err
);
    localparam int W  = 2 * no_of_digits + 1;
    localparam int DB = $clog2(radix);
    localparam int CW = $clog2(no_of_digits + delta + 2);

    typedef enum logic [1:0] {IDLE, SKIP, CONV, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   skip_cnt_q, dig_cnt_q;
    logic [W-1:0]    q_q, qm_q, q_d, qm_d;
    logic            err_q, ready_q, valid_q;
    logic            accept, nz, neg, pos, bad;
    logic [DB-1:0]   lo, lo_m1;

    assign accept = din_valid & ready_q;
    assign lo     = din[DB-1:0];
    assign lo_m1  = lo - DB'(1);
    assign nz     = |lo;
    assign neg    = din[radix_bits-1] & nz;
    assign pos    = ~din[radix_bits-1] & nz;
    // -4 has zero low bits with the sign set; it converts exactly like 0
    assign bad    = din[radix_bits-1] & ~nz;

    always_comb begin
        q_d  = neg ? {qm_q[W-DB-1:0], lo} : pos ? {q_q[W-DB-1:0], lo} : {q_q[W-DB-1:0], {DB{1'b0}}};
        qm_d = pos ? {q_q[W-DB-1:0], lo_m1} : neg ? {qm_q[W-DB-1:0], lo_m1} : {qm_q[W-DB-1:0], {DB{1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            q_q        <= '0;
            qm_q       <= '1;
            skip_cnt_q <= '0;
            dig_cnt_q  <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else if (start) begin
            state_q    <= (delta == 0) ? CONV : SKIP;
            q_q        <= '0;
            qm_q       <= '1;
            skip_cnt_q <= '0;
            dig_cnt_q  <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else if (accept) begin
            if (state_q == SKIP) begin
                skip_cnt_q <= skip_cnt_q + CW'(1);
                if (skip_cnt_q == CW'(delta - 1))
                    state_q <= CONV;
            end else if (state_q == CONV) begin
                q_q       <= q_d;
                qm_q      <= qm_d;
                err_q     <= err_q | bad;
                dig_cnt_q <= dig_cnt_q + CW'(1);
                if (dig_cnt_q == CW'(no_of_digits - 1)) begin
                    state_q <= DONE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign din_ready  = ready_q;
    assign dout_valid = valid_q;
    assign digit_err  = err_q;
    assign dout       = q_q;
endmodule

// File: doc/radix4_otf_convert.md
RADIX4_OTF_CONVERT -- requirements
Module: radix4_otf_convert

Interface
REQ-001 Parameter no_of_digits, default 4: number of significant radix-4 digits converted per result.
REQ-002 Parameter radix_bits, default 3: width of one signed digit, two's complement.
REQ-003 Parameter radix, default 4: number base; only 4 is supported.
REQ-004 Parameter delta, default 2: online delay; count of leading stream digits that are discarded.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a new conversion.
REQ-008 din  in  radix_bits  signed digit p_j, MSD first, legal values -3..+3.
REQ-009 din_valid  in  1  din is valid this cycle.
REQ-010 din_ready  out  1  block accepts din this cycle.
REQ-011 dout  out  2*no_of_digits+1  two's-complement integer Q = sum d_i*4^(no_of_digits-i).
REQ-012 dout_valid  out  1  dout holds a completed result.
REQ-013 digit_err  out  1  sticky flag: an illegal digit (-4) was accepted during the current conversion.

Function
REQ-014 Digit acceptance: a digit is accepted only in a cycle with din_valid=1 and din_ready=1; din_valid=0 stalls with no state change.
REQ-015 FSM states: IDLE, SKIP, CONV, DONE.
REQ-016 IDLE: din_ready=0; start moves the FSM to SKIP, or straight to CONV when delta=0.
REQ-017 SKIP: din_ready=1; each accepted digit increments the skip counter and is discarded; after the delta-th accepted digit, move to CONV.
REQ-018 CONV: din_ready=1; each accepted digit updates Q/QM (REQ-020) and increments the digit counter; after the no_of_digits-th accepted digit, move to DONE.
REQ-019 DONE: din_ready=0; dout_valid=1; dout holds Q until start or reset.
REQ-020 Conversion, on start: Q=0 and QM=-1 (all ones). For each accepted digit d:
  - d>0: Q'={Q,d[1:0]}, QM'={Q,(d-1)[1:0]}.
  - d=0: Q'={Q,2'b00}, QM'={QM,2'b11}.
  - d<0: Q'={QM,(4+d)[1:0]}, QM'={QM,(3+d)[1:0]}.
  - Invariant: QM=Q-1 after every step.
REQ-021 Q and QM are 2*no_of_digits+1 bits wide; a left shift by 2 drops the MSBs; the final result never overflows for legal digits.
REQ-022 Digit 3'b100 (-4) sets digit_err, is treated as d=0, and still counts as a digit.
REQ-023 Latency: dout_valid rises the cycle after the last digit is accepted.
REQ-024 start in any state (SKIP, CONV, or DONE) aborts the current work, clears counters, Q/QM, digit_err and dout_valid, then enters SKIP (or CONV when delta=0).
REQ-025 If start and din_valid are high in the same cycle, start wins and din is not accepted.
REQ-026 dout is Q in every state; it is only meaningful while dout_valid=1.

Reset
REQ-027 reset=1 forces, on the next edge: FSM=IDLE, Q=0, QM=-1, counters=0, dout_valid=0, din_ready=0, digit_err=0.
REQ-028 reset has priority over start and din_valid, including in the middle of a conversion.

Verification (no_of_digits=4, delta=2, 9-bit dout)
REQ-029 Basic conversion: start, then digits 2,-1 (skipped), then 1,-1,0,2 with din_valid held high -> dout=50, dout_valid=1 on the cycle after the 6th digit, digit_err=0.
REQ-030 Range extremes:
  - Digits x,x,3,3,3,3 -> dout=255.
  - Digits x,x,-3,-3,-3,-3 -> dout=-255 (9'h101).
REQ-031 Stalls: the REQ-029 stream with din_valid=0 gaps of 1-3 cycles between digits -> same dout=50; no digit is lost or duplicated.
REQ-032 Illegal digit: digits x,x,1,-4,0,0 -> dout=64, digit_err=1.
  - A following start clears digit_err and dout_valid.
REQ-033 Abort:
  - start pulsed after the 3rd CONV digit, then a full new stream x,x,0,0,0,1 -> dout=1.
  - reset asserted mid-CONV -> IDLE, din_ready=0, dout_valid=0 on the next cycle.
